// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the two-requester AXI read arbiter.
package axi_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } state_t;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   localparam int DEF_BURST_LEN  = 8;
   localparam int DEF_DATA_WIDTH = 64;

   // AXI arsize encoding: log2 of bytes per beat.
   function automatic int beat_size(input int data_width);
      return $clog2(data_width / 8);
   endfunction

   // Number of low address bits covered by one full line fill.
   function automatic int line_shift(input int burst_len, input int data_width);
      return $clog2(burst_len * data_width / 8);
   endfunction

   localparam int DEF_LINE_SHIFT = line_shift(DEF_BURST_LEN, DEF_DATA_WIDTH);
   localparam int DEF_BEAT_SIZE  = beat_size(DEF_DATA_WIDTH);

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// AXI read address/data channels between the arbiter and the memory side.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1; the source holds its payload stable while valid is 1 and ready is 0.
interface axi_rd_arbiter_if #(
   parameter int ID_WIDTH   = 13,
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 64
);
   import axi_arb_pkg::*;

   logic [ID_WIDTH-1:0]   m_axi_arid;
   logic [ADDR_WIDTH-1:0] m_axi_araddr;
   logic [7:0]            m_axi_arlen;
   logic [2:0]            m_axi_arsize;
   logic [1:0]            m_axi_arburst;
   logic                  m_axi_arvalid;
   logic                  m_axi_arready;
   logic [ID_WIDTH-1:0]   m_axi_rid;
   logic [DATA_WIDTH-1:0] m_axi_rdata;
   logic [1:0]            m_axi_rresp;
   logic                  m_axi_rlast;
   logic                  m_axi_rvalid;
   logic                  m_axi_rready;
   state_t                arb_state;   // arbiter FSM state, for debug/checkers

   modport master (
      output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
             m_axi_arvalid, m_axi_rready, arb_state,
      input  m_axi_arready, m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast,
             m_axi_rvalid
   );

   modport slave (
      input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
             m_axi_arvalid, m_axi_rready, arb_state,
      output m_axi_arready, m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast,
             m_axi_rvalid
   );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone request wins outright, a conflict goes to
// the requester that was not granted last.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] gnt
);

   // One-hot grant from the request vector and the last-granted pointer.
   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = last ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Arbitrates instruction-fetch and data line fills onto one AXI read port,
// one burst outstanding at a time, with R beats forwarded combinationally.
module axi_rd_arbiter
   import axi_arb_pkg::*;
#(
   parameter int ID_WIDTH   = 13,
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 64,
   parameter int BURST_LEN  = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [1:0]            req_valid,
   input  logic [ADDR_WIDTH-1:0] req0_addr,
   input  logic [ADDR_WIDTH-1:0] req1_addr,
   output logic [1:0]            req_ready,
   output logic [1:0]            resp_valid,
   output logic [DATA_WIDTH-1:0] resp_data,
   output logic                  resp_last,
   output logic                  resp_err,
   axi_rd_arbiter_if.master      m_axi
);

   localparam int SHIFT = line_shift(BURST_LEN, DATA_WIDTH);
   localparam int SIZE  = beat_size(DATA_WIDTH);
   localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);
   localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
      ~((ADDR_WIDTH'(1) << SHIFT) - ADDR_WIDTH'(1));

   state_t                state, nxt;
   logic                  g_q;       // requester owning the current burst
   logic                  last_q;    // requester granted most recently
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [CNT_W-1:0]      cnt_q;
   logic [1:0]            gnt;
   logic [ID_WIDTH-1:0]   cur_id;
   logic                  cnt_end;
   logic                  arvalid;
   logic                  rready;

   rr_arb2 u_rr (
      .req  (req_valid),
      .last (last_q),
      .gnt  (gnt)
   );

   assign cur_id  = ID_WIDTH'(g_q);
   assign cnt_end = (cnt_q == CNT_LAST);

   assign m_axi.m_axi_arid    = cur_id;
   assign m_axi.m_axi_araddr  = addr_q;
   assign m_axi.m_axi_arlen   = 8'(BURST_LEN - 1);
   assign m_axi.m_axi_arsize  = 3'(SIZE);
   assign m_axi.m_axi_arburst = BURST_INCR;
   assign m_axi.m_axi_arvalid = arvalid;
   assign m_axi.m_axi_rready  = rready;
   assign m_axi.arb_state     = state;
   assign resp_data           = m_axi.m_axi_rdata;

   // Next state plus grant, AR valid and R forwarding. Reset gates the grant
   // so req_ready is 0 while reset_n is held low. The burst ends on rlast or
   // on the last counted beat, whichever comes first; disagreement is an error.
   always_comb begin
      nxt        = state;
      req_ready  = 2'b00;
      resp_valid = 2'b00;
      resp_last  = 1'b0;
      resp_err   = 1'b0;
      arvalid    = 1'b0;
      rready     = 1'b0;
      case (state)
         IDLE: begin
            if (reset_n && (req_valid != 2'b00)) begin
               req_ready = gnt;
               nxt       = ADDR;
            end
         end
         ADDR: begin
            arvalid = 1'b1;
            if (m_axi.m_axi_arready) nxt = DATA;
         end
         DATA: begin
            rready = 1'b1;
            if (m_axi.m_axi_rvalid) begin
               resp_valid[g_q] = 1'b1;
               resp_last = m_axi.m_axi_rlast | cnt_end;
               resp_err  = (m_axi.m_axi_rresp != 2'b00) |
                           (m_axi.m_axi_rid != cur_id) |
                           (m_axi.m_axi_rlast != cnt_end);
               if (resp_last) nxt = IDLE;
            end
         end
         default: nxt = IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= nxt;
   end

   // Grant latch, line address, beat counter and round-robin pointer.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         g_q    <= 1'b0;
         last_q <= 1'b1;
         addr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (state == IDLE && nxt == ADDR) begin
            g_q    <= gnt[1];
            addr_q <= (gnt[1] ? req1_addr : req0_addr) & LINE_MASK;
         end
         if (state == ADDR && nxt == DATA)
            cnt_q <= '0;
         else if (state == DATA && m_axi.m_axi_rvalid)
            cnt_q <= cnt_q + CNT_W'(1);
         if (state == DATA && nxt == IDLE)
            last_q <= g_q;
      end
   end

endmodule

// File: doc/axi_rd_arbiter.md
AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- ID_WIDTH, 13, AXI ID width.
- ADDR_WIDTH, 64, address width.
- DATA_WIDTH, 64, data width.
- BURST_LEN, 8, beats per line fill.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, sole clock.
- reset_n, in, 1, asynchronous active-low reset.
- req_valid, in, 2, line-fill request; bit0 = instruction fetch, bit1 = data.
- req0_addr, in, ADDR_WIDTH, requester-0 address.
- req1_addr, in, ADDR_WIDTH, requester-1 address.
- req_ready, out, 2, one-cycle accept pulse to the granted requester.
- resp_valid, out, 2, data beat for requester g.
- resp_data, out, DATA_WIDTH, beat data, shared by both requesters.
- resp_last, out, 1, final beat of the burst.
- resp_err, out, 1, beat carries an error.
- m_axi_arid, out, ID_WIDTH, read ID.
- m_axi_araddr, out, ADDR_WIDTH, read address.
- m_axi_arlen, out, 8, burst length.
- m_axi_arsize, out, 3, beat size.
- m_axi_arburst, out, 2, burst type.
- m_axi_arvalid, out, 1, AR valid.
- m_axi_arready, in, 1, AR ready.
- m_axi_rid, in, ID_WIDTH, R ID.
- m_axi_rdata, in, DATA_WIDTH, R data.
- m_axi_rresp, in, 2, R response.
- m_axi_rlast, in, 1, R last.
- m_axi_rvalid, in, 1, R valid.
- m_axi_rready, out, 1, R ready.

Function
REQ-003 FSM states SHALL be IDLE, ADDR and DATA; only one burst is ever outstanding.
REQ-004 In IDLE with any req_valid bit set, the FSM SHALL grant one requester g, assert req_ready[g] combinationally in that same cycle, latch g and the address, and enter ADDR.
REQ-005 Arbitration SHALL be round-robin: on a conflict, grant the requester not granted last; after reset, requester 0 wins the first conflict.
REQ-006 The latched address SHALL be the requester address with its low log2(BURST_LEN*DATA_WIDTH/8) bits cleared.
REQ-007 In ADDR, arvalid SHALL be 1 and araddr/arid SHALL hold constant until arready.
REQ-008 AR field values SHALL be: arid = g zero-extended, arlen = BURST_LEN-1, arsize = log2(DATA_WIDTH/8), arburst = INCR (2'b01).
REQ-009 The arvalid&&arready handshake in ADDR SHALL move the FSM to DATA and clear the beat counter.
REQ-010 In DATA, rready SHALL be 1 and requesters SHALL NOT back-pressure.
REQ-011 On each R beat, resp_valid[g] SHALL equal rvalid and resp_data SHALL equal rdata combinationally (zero added latency).
REQ-012 resp_err SHALL be 1 on a beat whose rresp != 0 or whose rid != arid.
REQ-013 Burst end: a beat with rlast, or the beat where counter == BURST_LEN-1, SHALL assert resp_last, update the round-robin pointer and return to IDLE on the next edge.
REQ-014 If rlast and the counter disagree, that final beat SHALL also assert resp_err.
REQ-015 Outside DATA, resp_valid, resp_last, resp_err and rready SHALL be 0; R beats arriving then are ignored.
REQ-016 A new request SHALL NOT be granted in the same cycle the FSM leaves DATA; minimum request-to-request spacing is one IDLE cycle.

Reset
REQ-017 reset_n low SHALL immediately force: state IDLE, arvalid 0, rready 0, req_ready 0, resp_valid 0, round-robin pointer = requester 1 (so requester 0 wins first) — including mid-burst; any partial burst is abandoned.

Structure
REQ-018 Package axi_arb_pkg SHALL hold the state enum, the AXI burst encodings and the BURST_LEN-derived shift/size constants.
REQ-019 The 2-way round-robin grant logic SHALL be a sub-module rr_arb2 (inputs req[1:0] and last; outputs gnt[1:0]).

Verification
REQ-020 The bench SHALL cover these directed scenarios (stimulus -> required response):
- Single request: req_valid = 01, req0_addr = 0x1000_0048 -> req_ready = 01 same cycle; araddr = 0x1000_0040, arlen = 7, arsize = 3, arburst = 1, arid = 0; 8 resp_valid[0] beats, last one with resp_last.
- Conflict: req_valid = 11 held -> grants alternate 0, 1, 0; each burst completes before the next AR.
- arready low 5 cycles -> arvalid held and araddr stable throughout; no R activity forwarded.
- rresp = 2 on beat 3 -> resp_err = 1 on that beat only; burst still completes.
- Early rlast on beat 5 -> resp_last and resp_err on beat 5, FSM returns to IDLE.
- reset_n pulsed low during beat 4 -> outputs zero immediately; next request granted to requester 0.
